// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch stage
// (read-only) and the memory stage (load/store). One transaction is outstanding at a time.
// Data requests win over fetch requests. A watchdog abandons transactions whose mem_ready
// never arrives.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   if_req/if_addr/if_kill      fetch request, address, discard-in-flight (PCSrcE)
//   if_rdata/if_valid           fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request (store when d_we)
//   d_rdata/d_valid             load data and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request side (registered)
//   mem_rdata/mem_ready         memory response, ready is a one-cycle pulse
//   StallMemF/StallMemM         pipeline freeze requests for the hazard unit
//   mem_err                     sticky watchdog-timeout flag
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            StallMemF,
  output logic            StallMemM,
  output logic            mem_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StDBusy, StIBusy, StIKill} arbStateT;

  arbStateT        stateQ, stateD;
  logic [CntW-1:0] waitCnt;
  logic            grantD, grantI, busy, timeout, done;
  logic [DW-1:0]   rdataSel;

  // A request whose valid is high this cycle is being consumed, not re-issued.
  assign grantD = d_req & ~d_valid;
  assign grantI = if_req & ~if_valid;

  assign busy    = (stateQ != StIdle);
  assign timeout = busy && !mem_ready && (TIMEOUT != 0) && (32'(waitCnt) == TIMEOUT - 1);
  assign done    = busy && (mem_ready || timeout);

  // A timed-out transaction returns zero data.
  assign rdataSel = mem_ready ? mem_rdata : '0;

  assign StallMemF = if_req & ~if_valid;
  assign StallMemM = d_req & ~d_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (grantD) begin
          stateD = StDBusy;
        end else if (grantI) begin
          stateD = if_kill ? StIKill : StIBusy;
        end
      end
      StDBusy: begin
        if (done) stateD = StIdle;
      end
      StIBusy: begin
        if (done) begin
          stateD = StIdle;
        end else if (if_kill) begin
          stateD = StIKill;
        end
      end
      StIKill: begin
        if (done) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req = busy;
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      mem_err   <= 1'b0;
      waitCnt   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (stateQ == StIdle) begin
        if (grantD) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_wstrb <= d_we ? d_wstrb : '0;
          mem_we    <= d_we;
          waitCnt   <= '0;
        end else if (grantI) begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          mem_we    <= 1'b0;
          waitCnt   <= '0;
        end
      end else if (done) begin
        mem_we <= 1'b0;
        if (timeout) mem_err <= 1'b1;
        if (stateQ == StDBusy) begin
          d_valid <= 1'b1;
          d_rdata <= rdataSel;
        end
        // A kill arriving together with completion still discards the fetch.
        if ((stateQ == StIBusy) && !if_kill) begin
          if_valid <= 1'b1;
          if_rdata <= rdataSel;
        end
      end else begin
        waitCnt <= waitCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4). A memory model pops the
// expected memory transaction when mem_req rises and answers after a per-transaction
// wait count; a monitor pops the expected completion on each valid pulse.
module tb_mem_port_arbiter;

  localparam int unsigned Timeout = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          hang;
  } memTxnT;

  typedef struct {
    bit          isData;
    logic [31:0] rdata;
    bit          chkData;
  } respT;

  logic        clk, reset;
  logic        if_req, if_kill, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallMemF, StallMemM, mem_err;

  memTxnT memQ[$];
  respT   respQ[$];
  memTxnT cur;
  bit     inTxn;
  int     busyCyc;
  int     nChecks = 0;
  int     nPass = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallMemF(StallMemF), .StallMemM(StallMemM), .mem_err(mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void pushMem(input logic [31:0] addr, input logic we,
                                  input logic [3:0] wstrb, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int waits, input bit hang);
    memTxnT t;
    t.addr = addr; t.we = we; t.wstrb = wstrb; t.wdata = wdata;
    t.rdata = rdata; t.waits = waits; t.hang = hang;
    memQ.push_back(t);
  endfunction

  function automatic void pushResp(input bit isData, input logic [31:0] rdata,
                                   input bit chkData);
    respT r;
    r.isData = isData; r.rdata = rdata; r.chkData = chkData;
    respQ.push_back(r);
  endfunction

  // Memory model: mem_ready after cur.waits busy cycles, never when cur.hang.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (reset) begin
      inTxn = 1'b0;
    end else if (mem_req) begin
      if (!inTxn) begin
        if (memQ.size() == 0) check("unexpectedMemTxn", memQ.size(), 1);
        else cur = memQ.pop_front();
        inTxn   = 1'b1;
        busyCyc = 0;
      end
      check("memAddr", mem_addr, cur.addr);
      check("memWe", {31'b0, mem_we}, {31'b0, cur.we});
      check("memWstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
      check("memWdata", mem_wdata, cur.wdata);
      busyCyc++;
      if (!cur.hang && busyCyc == cur.waits + 1) begin
        mem_ready = 1'b1;
        mem_rdata = cur.rdata;
      end
    end else if (inTxn) begin
      inTxn = 1'b0;
      if (cur.hang) check("watchdogLen", busyCyc, Timeout);
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    respT r;
    if (!reset && (if_valid || d_valid)) begin
      if (respQ.size() == 0) begin
        check("spuriousValid", respQ.size(), 1);
      end else begin
        r = respQ.pop_front();
        check("validPort", {31'b0, d_valid}, {31'b0, r.isData});
        if (r.chkData) check("rdata", r.isData ? d_rdata : if_rdata, r.rdata);
        check("stallAtValid", {31'b0, r.isData ? StallMemM : StallMemF}, 32'd0);
      end
    end
  end

  // Holds each request until its valid, then drops it on the following cycle.
  task automatic runUntilDone(input int budget);
    int  n = 0;
    bit  dropI, dropD;
    while ((if_req || d_req) && n < budget) begin
      @(negedge clk);
      dropI = if_valid;
      dropD = d_valid;
      @(posedge clk); #1;
      if (dropI) if_req = 1'b0;
      if (dropD) d_req = 1'b0;
      n++;
    end
    check("reqBudget", {31'b0, (if_req || d_req)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL globalTimeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rstMemReq", {31'b0, mem_req}, 0);
    check("rstMemWe", {31'b0, mem_we}, 0);
    check("rstMemAddr", mem_addr, 0);
    check("rstMemWstrb", {28'b0, mem_wstrb}, 0);
    check("rstIfValid", {31'b0, if_valid}, 0);
    check("rstDValid", {31'b0, d_valid}, 0);
    check("rstMemErr", {31'b0, mem_err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: fetch with two wait states; valid at cycle 4
    pushMem(32'h100, 1'b0, 4'h0, 32'h0, 32'h00500093, 2, 1'b0);
    pushResp(1'b0, 32'h00500093, 1'b1);
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t1StallF_c%0d", c), {31'b0, StallMemF}, {31'b0, (c < 4)});
      check($sformatf("t1IfValid_c%0d", c), {31'b0, if_valid}, {31'b0, (c == 4)});
      check($sformatf("t1MemReq_c%0d", c), {31'b0, mem_req}, {31'b0, (c >= 1 && c <= 3)});
      @(posedge clk); #1;
    end
    if_req = 1'b0;

    // 2: simultaneous load and fetch; data first. Load strobes must be masked.
    pushMem(32'h2000, 1'b0, 4'h0, 32'h0, 32'h11223344, 1, 1'b0);
    pushResp(1'b1, 32'h11223344, 1'b1);
    pushMem(32'h180, 1'b0, 4'h0, 32'h0, 32'h00000013, 0, 1'b0);
    pushResp(1'b0, 32'h00000013, 1'b1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h180;
    runUntilDone(40);

    // 3: store
    pushMem(32'h40, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h55AA55AA, 1, 1'b0);
    pushResp(1'b1, 32'h0, 1'b0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    @(negedge clk);
    check("t3StallM", {31'b0, StallMemM}, 1);
    @(posedge clk); #1;
    runUntilDone(40);
    d_we = 1'b0; d_wdata = '0; d_wstrb = '0;

    // 4: kill one cycle into a fetch; redirected fetch follows
    pushMem(32'h100, 1'b0, 4'h0, 32'h0, 32'hBAD0BAD0, 3, 1'b0);
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk); #1;
    pushMem(32'h200, 1'b0, 4'h0, 32'h0, 32'h00A00113, 0, 1'b0);
    pushResp(1'b0, 32'h00A00113, 1'b1);
    if_kill = 1'b1; if_addr = 32'h200;
    @(posedge clk); #1;
    if_kill = 1'b0;
    runUntilDone(40);

    // 5: watchdog on a load that never completes
    check("t5ErrBefore", {31'b0, mem_err}, 0);
    pushMem(32'h3000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b1);
    pushResp(1'b1, 32'h0, 1'b1);
    d_req = 1'b1; d_addr = 32'h3000;
    runUntilDone(40);
    @(negedge clk);
    check("t5MemErr", {31'b0, mem_err}, 1);
    check("t5MemReq", {31'b0, mem_req}, 0);
    @(posedge clk); #1;

    // 6: reset in the middle of a load
    pushMem(32'h3004, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b1);
    d_req = 1'b1; d_addr = 32'h3004;
    @(negedge clk);
    @(negedge clk);
    check("t6Busy", {31'b0, mem_req}, 1);
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    #1;
    check("t6RstMemReq", {31'b0, mem_req}, 0);
    check("t6RstMemAddr", mem_addr, 0);
    check("t6RstMemErr", {31'b0, mem_err}, 0);
    check("t6RstDRdata", d_rdata, 0);
    check("t6RstIfRdata", if_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6NoDValid", {31'b0, d_valid}, 0);
      check("t6NoMemReq", {31'b0, mem_req}, 0);
    end

    check("memQEmpty", memQ.size(), 0);
    check("respQEmpty", respQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
